vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 131 +++++++++++++
 tb/tb_vga_sync_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position and timing lock from a VGA sync stream sampled on a pixel strobe.
// Optional err_count output is built when VGA_SYNC_DECODER_ERRCNT_EN is defined.
module vga_sync_decoder #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        pix_en,
    input  logic        hs_n,
    input  logic        vs_n,
    input  logic        blank_n,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        err
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [10:0] H_TOT_C  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_C  = 11'(V_TOTAL);
    localparam logic [10:0] WIDTH_C  = 11'(WIDTH);
    localparam logic [10:0] HEIGHT_C = 11'(HEIGHT);

    logic       hs_q, vs_q, blank_q;
    logic [9:0] hcnt, vcnt;
    logic [1:0] state, state_nxt;
    logic       align_bad, align_bad_nxt;

    logic hs_fall, vs_fall, blank_fall, blank_rise, blank_run;
    logic line_bad, frame_bad, run_bad, viol, err_nxt;

    // Edges compare the live inputs against the previous strobe's sample.
    assign hs_fall    = pix_en & hs_q & ~hs_n;
    assign vs_fall    = pix_en & vs_q & ~vs_n;
    assign blank_fall = pix_en & blank_q & ~blank_n;
    assign blank_rise = pix_en & ~blank_q & blank_n;
    assign blank_run  = pix_en & blank_q & blank_n;

    assign line_bad  = hs_fall & ((hcnt == 10'h3FF) | (({1'b0, hcnt} + 11'd1) != H_TOT_C));
    assign frame_bad = vs_fall & ((vcnt == 10'h3FF) | ({1'b0, vcnt} != V_TOT_C));
    assign run_bad   = blank_fall & ((x == 10'h3FF) | (({1'b0, x} + 11'd1) != WIDTH_C)
                                     | ({2'b00, y} >= HEIGHT_C));
    assign viol      = line_bad | frame_bad | run_bad;
    assign err_nxt   = viol & (state != ST_SEARCH);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SEARCH: if (vs_fall) state_nxt = ST_ALIGN;
            ST_ALIGN:  if (vs_fall) state_nxt = (align_bad | viol) ? ST_SEARCH : ST_LOCKED;
            ST_LOCKED: if (viol) state_nxt = ST_SEARCH;
            default:   state_nxt = ST_SEARCH;
        endcase
    end

    // A violation anywhere in the ALIGN frame blocks the lock at its closing vs_n fall.
    always_comb begin
        align_bad_nxt = 1'b0;
        if (state_nxt == ST_ALIGN && state == ST_ALIGN)
            align_bad_nxt = align_bad | viol;
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b1;
            hcnt        <= '0;
            vcnt        <= '0;
            x           <= '0;
            y           <= '0;
            state       <= ST_SEARCH;
            align_bad   <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else begin
            pix_valid   <= pix_en & blank_n & (state_nxt == ST_LOCKED);
            frame_start <= vs_fall & (state == ST_LOCKED);
            err         <= err_nxt;
            state       <= state_nxt;
            align_bad   <= align_bad_nxt;
            if (pix_en) begin
                hs_q    <= hs_n;
                vs_q    <= vs_n;
                blank_q <= blank_n;
                if (hs_fall)
                    hcnt <= '0;
                else if (hcnt != 10'h3FF)
                    hcnt <= hcnt + 10'd1;
                if (blank_rise)
                    x <= '0;
                else if (blank_run && x != 10'h3FF)
                    x <= x + 10'd1;
            end
            // A coincident hs_n fall is line 0 of the new frame, so it counts.
            if (vs_fall)
                vcnt <= hs_fall ? 10'd1 : 10'd0;
            else if (hs_fall && vcnt != 10'h3FF)
                vcnt <= vcnt + 10'd1;
            if (vs_fall)
                y <= '0;
            else if (blank_fall && y != 9'h1FF)
                y <= y + 9'd1;
        end
    end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            err_count <= '0;
        else if (err_nxt && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled 8x4 raster (16 strobes x 10 lines).
// Defining VGA_SYNC_DECODER_ERRCNT_EN also connects and checks err_count.
module tb_vga_sync_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       pix_en   = 1'b0;
    logic       hs_n     = 1'b1;
    logic       vs_n     = 1'b1;
    logic       blank_n  = 1'b0;
    logic [9:0] x;
    logic [8:0] y;
    logic       pix_valid, frame_start, locked, err;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    vga_sync_decoder #(.WIDTH(8), .HEIGHT(4), .H_TOTAL(16), .V_TOTAL(10)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .pix_en(pix_en),
        .hs_n(hs_n), .vs_n(vs_n), .blank_n(blank_n),
        .x(x), .y(y), .pix_valid(pix_valid), .frame_start(frame_start),
        .locked(locked), .err(err)
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int err_seen, fs_seen, pv_seen, leak;
    logic       h0_err [16];
    logic       h0_fs  [16];
    logic       h0_lk  [16];
    logic       end_lk [16];
    logic [9:0] fa_x [16], la_x [16];
    logic [8:0] fa_y [16], la_y [16];
    logic       fa_pv[16], la_pv[16];

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic h, input logic v, input logic b);
        @(negedge CLOCK_50);
        if (pix_valid || frame_start || err) leak++;
        hs_n = h; vs_n = v; blank_n = b; pix_en = 1'b1;
        @(negedge CLOCK_50);
        pix_en = 1'b0;
        err_seen += int'(err);
        fs_seen  += int'(frame_start);
        pv_seen  += int'(pix_valid);
    endtask

    task automatic send_line(input int v, input int len, input int act);
        for (int h = 0; h < len; h++) begin
            strobe(h >= 2, v >= 2, act > 0 && h >= 4 && h < 4 + act);
            if (h == 0) begin h0_err[v] = err; h0_fs[v] = frame_start; h0_lk[v] = locked; end
            if (act > 0 && h == 4) begin fa_x[v] = x; fa_y[v] = y; fa_pv[v] = pix_valid; end
            if (act > 0 && h == 3 + act) begin la_x[v] = x; la_y[v] = y; la_pv[v] = pix_valid; end
        end
        end_lk[v] = locked;
    endtask

    task automatic send_frame(input int nlines, input int mod_v, input int mod_len, input int mod_act);
        err_seen = 0; fs_seen = 0; pv_seen = 0;
        for (int v = 0; v < nlines; v++) begin
            if (v == mod_v) send_line(v, mod_len, mod_act);
            else            send_line(v, 16, (v >= 3 && v <= 6) ? 8 : 0);
        end
    endtask

    task automatic relock();
        send_frame(10, -1, 16, 0);
        send_frame(10, -1, 16, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++; if (x !== 10'd0)        begin errors++; $display("FAIL reset_x: got %0d expected 0", x); end
        checks++; if (y !== 9'd0)         begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b expected 0", pix_valid); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        reset_n = 1'b1;
    endtask

    task automatic test_acquire();
        int fs_total;
        send_frame(10, -1, 16, 0);
        fs_total = fs_seen;
        checks++; if (end_lk[9] !== 1'b0) begin errors++; $display("FAIL acq_align_unlocked: got %b expected 0", end_lk[9]); end
        checks++; if (err_seen != 0)      begin errors++; $display("FAIL acq_err_f1: got %0d expected 0", err_seen); end
        send_frame(10, -1, 16, 0);
        fs_total += fs_seen;
        checks++; if (h0_lk[0] !== 1'b1)  begin errors++; $display("FAIL acq_lock_2nd_vs: got %b expected 1", h0_lk[0]); end
        checks++; if (fs_total != 0)      begin errors++; $display("FAIL acq_fs_early: got %0d expected 0", fs_total); end
        checks++; if (err_seen != 0)      begin errors++; $display("FAIL acq_err_f2: got %0d expected 0", err_seen); end
    endtask

    task automatic test_position();
        send_frame(10, -1, 16, 0);
        checks++; if (h0_fs[0] !== 1'b1) begin errors++; $display("FAIL pos_fs_3rd_vs: got %b expected 1", h0_fs[0]); end
        checks++; if (fs_seen != 1)      begin errors++; $display("FAIL pos_fs_count: got %0d expected 1", fs_seen); end
        checks++; if (fa_x[3] !== 10'd0) begin errors++; $display("FAIL pos_first_x: got %0d expected 0", fa_x[3]); end
        checks++; if (fa_y[3] !== 9'd0)  begin errors++; $display("FAIL pos_first_y: got %0d expected 0", fa_y[3]); end
        checks++; if (fa_pv[3] !== 1'b1) begin errors++; $display("FAIL pos_first_pv: got %b expected 1", fa_pv[3]); end
        checks++; if (la_x[6] !== 10'd7) begin errors++; $display("FAIL pos_last_x: got %0d expected 7", la_x[6]); end
        checks++; if (la_y[6] !== 9'd3)  begin errors++; $display("FAIL pos_last_y: got %0d expected 3", la_y[6]); end
        checks++; if (pv_seen != 32)     begin errors++; $display("FAIL pos_pv_count: got %0d expected 32", pv_seen); end
    endtask

    task automatic test_idle_hold();
        repeat (6) @(negedge CLOCK_50);
        checks++; if (x !== 10'd7)    begin errors++; $display("FAIL idle_x: got %0d expected 7", x); end
        checks++; if (y !== 9'd4)     begin errors++; $display("FAIL idle_y: got %0d expected 4", y); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL idle_locked: got %b expected 1", locked); end
        checks++; if ({pix_valid, frame_start, err} !== 3'b000)
            begin errors++; $display("FAIL idle_pulses: got %b expected 000", {pix_valid, frame_start, err}); end
    endtask

    task automatic test_short_line();
        send_frame(10, 4, 15, 8);
        checks++; if (h0_err[5] !== 1'b1) begin errors++; $display("FAIL short_err_at_hs: got %b expected 1", h0_err[5]); end
        checks++; if (h0_lk[5] !== 1'b0)  begin errors++; $display("FAIL short_unlock: got %b expected 0", h0_lk[5]); end
        checks++; if (err_seen != 1)      begin errors++; $display("FAIL short_err_count: got %0d expected 1", err_seen); end
        checks++; if (pv_seen != 16)      begin errors++; $display("FAIL short_pv_after: got %0d expected 16", pv_seen); end
        send_frame(10, -1, 16, 0);
        checks++; if (pv_seen != 0)       begin errors++; $display("FAIL short_pv_align: got %0d expected 0", pv_seen); end
        checks++; if (h0_lk[0] !== 1'b0)  begin errors++; $display("FAIL short_align_lock: got %b expected 0", h0_lk[0]); end
        send_frame(10, -1, 16, 0);
        checks++; if (h0_lk[0] !== 1'b1)  begin errors++; $display("FAIL short_relock: got %b expected 1", h0_lk[0]); end
        checks++; if (h0_fs[0] !== 1'b0)  begin errors++; $display("FAIL short_relock_fs: got %b expected 0", h0_fs[0]); end
    endtask

    task automatic test_long_run();
        send_frame(10, 4, 16, 9);
        checks++; if (err_seen != 1)     begin errors++; $display("FAIL long_err_count: got %0d expected 1", err_seen); end
        checks++; if (la_x[4] !== 10'd8) begin errors++; $display("FAIL long_last_x: got %0d expected 8", la_x[4]); end
        checks++; if (end_lk[4] !== 1'b0) begin errors++; $display("FAIL long_unlock: got %b expected 0", end_lk[4]); end
        relock();
        checks++; if (h0_lk[0] !== 1'b1) begin errors++; $display("FAIL long_relock: got %b expected 1", h0_lk[0]); end
    endtask

    task automatic test_extra_run();
        send_frame(10, 7, 16, 8);
        checks++; if (err_seen != 1)      begin errors++; $display("FAIL extra_err_count: got %0d expected 1", err_seen); end
        checks++; if (end_lk[7] !== 1'b0) begin errors++; $display("FAIL extra_unlock: got %b expected 0", end_lk[7]); end
        relock();
    endtask

    task automatic test_short_frame();
        send_frame(9, -1, 16, 0);
        checks++; if (err_seen != 0)      begin errors++; $display("FAIL sframe_err_early: got %0d expected 0", err_seen); end
        send_frame(10, -1, 16, 0);
        checks++; if (h0_err[0] !== 1'b1) begin errors++; $display("FAIL sframe_err: got %b expected 1", h0_err[0]); end
        checks++; if (h0_fs[0] !== 1'b1)  begin errors++; $display("FAIL sframe_fs: got %b expected 1", h0_fs[0]); end
        checks++; if (h0_lk[0] !== 1'b0)  begin errors++; $display("FAIL sframe_unlock: got %b expected 0", h0_lk[0]); end
        checks++; if (err_seen != 1)      begin errors++; $display("FAIL sframe_err_count: got %0d expected 1", err_seen); end
        relock();
        checks++; if (h0_lk[0] !== 1'b1)  begin errors++; $display("FAIL sframe_relock: got %b expected 1", h0_lk[0]); end
    endtask

    task automatic test_reset_midline();
        for (int v = 0; v < 4; v++) send_line(v, 16, (v == 3) ? 8 : 0);
        for (int h = 0; h < 8; h++) strobe(1'b1, 1'b1, h >= 4);
        checks++; if (x !== 10'd3 || pix_valid !== 1'b1)
            begin errors++; $display("FAIL mid_pre: got x=%0d pv=%b expected x=3 pv=1", x, pix_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (x !== 10'd0)        begin errors++; $display("FAIL mid_x: got %0d expected 0", x); end
        checks++; if (y !== 9'd0)         begin errors++; $display("FAIL mid_y: got %0d expected 0", y); end
        checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL mid_locked: got %b expected 0", locked); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL mid_pv: got %b expected 0", pix_valid); end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        err_seen = 0;
        send_line(5, 10, 8);
        for (int v = 6; v < 10; v++) send_line(v, 16, (v == 6) ? 8 : 0);
        checks++; if (err_seen != 0)      begin errors++; $display("FAIL mid_search_err: got %0d expected 0", err_seen); end
        send_frame(10, -1, 16, 0);
        checks++; if (h0_lk[0] !== 1'b0)  begin errors++; $display("FAIL mid_no_early_lock: got %b expected 0", h0_lk[0]); end
        send_frame(10, -1, 16, 0);
        checks++; if (h0_lk[0] !== 1'b1)  begin errors++; $display("FAIL mid_relock: got %b expected 1", h0_lk[0]); end
    endtask

    task automatic test_errcnt();
        int total;
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        total = 0;
        send_frame(10, -1, 16, 0);  total += err_seen;
        send_frame(10, 4, 15, 8);   total += err_seen;
        send_frame(10, -1, 16, 0);  total += err_seen;
        checks++; if (h0_lk[0] !== 1'b0) begin errors++; $display("FAIL ecnt_bad_align: got %b expected 0", h0_lk[0]); end
        send_frame(10, 4, 15, 8);   total += err_seen;
        send_frame(10, -1, 16, 0);  total += err_seen;
        send_frame(10, 4, 15, 8);   total += err_seen;
        checks++; if (total != 3)        begin errors++; $display("FAIL ecnt_err_pulses: got %0d expected 3", total); end
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL ecnt_value: got %0d expected 3", err_count); end
`endif
    endtask

    task automatic test_pulse_leak();
        checks++; if (leak != 0) begin errors++; $display("FAIL pulse_leak: got %0d expected 0", leak); end
    endtask

    initial begin
        leak = 0; err_seen = 0; fs_seen = 0; pv_seen = 0;
        test_reset();
        test_acquire();
        test_position();
        test_idle_hold();
        test_short_line();
        test_long_run();
        test_extra_run();
        test_short_frame();
        test_reset_midline();
        test_errcnt();
        test_pulse_leak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
